envelope_follower: RTL and testbench

//  Inverse of the ADSR envelope generator: measures the amplitude envelope of an incoming audio

---
 rtl/envelope_follower_pkg.sv | 23 ++
 rtl/envelope_follower_tick_gen.sv | 21 ++
 rtl/envelope_follower.sv | 146 ++++++++++++++
 tb/tb_envelope_follower.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/envelope_follower_pkg.sv
// Shared types and helpers for the envelope follower: gate FSM encoding,
// envelope width and the saturating rectifier.
package envelope_follower_pkg;

    localparam int ENV_W = 6;

    typedef enum logic [1:0] {
        GATE_IDLE = 2'd0,
        GATE_ON   = 2'd1,
        GATE_HOLD = 2'd2
    } gate_state_t;

    // |x| clamped to 2^(w-1)-1, then reduced to its top ENV_W magnitude bits.
    function automatic logic [ENV_W-1:0] sat_mag6(input logic signed [31:0] x, input int unsigned w);
        logic [31:0] lim;
        logic [31:0] m;
        lim = (32'd1 << (w - 1)) - 32'd1;
        m   = x[31] ? 32'(-x) : 32'(x);
        if (m > lim) m = lim;
        return ENV_W'(m >> (w - 1 - ENV_W));
    endfunction

endpackage

// File: rtl/envelope_follower_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset)    cnt <= '0;
        else if (tick) cnt <= '0;
        else           cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/envelope_follower.sv
// Envelope follower: rectify, window-peak, slew-limited envelope per tick and a
// hysteresis/hold gate. Optional DC blocker enabled by ENV_FOLLOWER_DC_BLOCK_EN.
module envelope_follower
    import envelope_follower_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int TICK_DIV = 50000,
    parameter int DC_SHIFT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic [ENV_W-1:0]         attack_rate,
    input  logic [ENV_W-1:0]         release_rate,
    input  logic [ENV_W-1:0]         thr_on,
    input  logic [ENV_W-1:0]         thr_off,
    input  logic [ENV_W-1:0]         hold_ticks,
    output logic [ENV_W-1:0]         env_level,
    output logic                     gate_out,
    output logic                     gate_rise
);
    logic                     tick;
    logic signed [DATA_W-1:0] rect_in;
    logic                     rect_valid;
    logic [ENV_W-1:0]         mag6, peak, peak_in, env_next;
    logic [ENV_W:0]           up, dn, att7, rel7;
    gate_state_t              state, state_next;
    logic [ENV_W-1:0]         hold_cnt, hold_next, thr_offe;
    logic                     rise_next;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

`ifdef ENV_FOLLOWER_DC_BLOCK_EN
    localparam int IW = DATA_W + 2;
    localparam logic signed [IW-1:0] Y_MAX = IW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [IW-1:0] Y_MIN = -IW'(2 ** (DATA_W - 1));

    logic signed [IW-1:0]     x_prev, y_prev, y_raw;
    logic signed [DATA_W-1:0] y_sat, dc_y;
    logic                     dc_valid;

    always_comb begin
        y_raw = IW'(sample_in) - x_prev + y_prev - (y_prev >>> DC_SHIFT);
        if (y_raw > Y_MAX)      y_sat = Y_MAX[DATA_W-1:0];
        else if (y_raw < Y_MIN) y_sat = Y_MIN[DATA_W-1:0];
        else                    y_sat = y_raw[DATA_W-1:0];
    end

    // The filtered sample is registered, so the rectifier sees it one cycle late.
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_prev   <= '0;
            y_prev   <= '0;
            dc_y     <= '0;
            dc_valid <= 1'b0;
        end else begin
            dc_valid <= sample_valid;
            if (sample_valid) begin
                x_prev <= IW'(sample_in);
                y_prev <= IW'(y_sat);
                dc_y   <= y_sat;
            end
        end
    end

    assign rect_in    = dc_y;
    assign rect_valid = dc_valid;
`else
    assign rect_in    = sample_in;
    assign rect_valid = sample_valid;
`endif

    assign mag6 = sat_mag6(32'(rect_in), DATA_W);

    // A sample landing on the tick cycle still belongs to the closing window.
    always_comb begin
        peak_in  = (rect_valid && mag6 > peak) ? mag6 : peak;
        up       = {1'b0, peak_in} - {1'b0, env_level};
        dn       = {1'b0, env_level} - {1'b0, peak_in};
        att7     = {1'b0, attack_rate};
        rel7     = {1'b0, release_rate};
        env_next = env_level;
        if (peak_in > env_level)
            env_next = ENV_W'({1'b0, env_level} + ((up < att7) ? up : att7));
        else if (peak_in < env_level)
            env_next = ENV_W'({1'b0, env_level} - ((dn < rel7) ? dn : rel7));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            env_level <= '0;
            peak      <= '0;
        end else if (tick) begin
            env_level <= env_next;
            peak      <= '0;
        end else begin
            peak      <= peak_in;
        end
    end

    assign thr_offe = (thr_off < thr_on) ? thr_off : thr_on;

    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        rise_next  = 1'b0;
        case (state)
            GATE_IDLE: if (env_level >= thr_on) begin
                state_next = GATE_ON;
                rise_next  = 1'b1;
            end
            GATE_ON: if (env_level < thr_offe) begin
                state_next = GATE_HOLD;
                hold_next  = hold_ticks;
            end
            GATE_HOLD: begin
                if (env_level >= thr_on)  state_next = GATE_ON;
                else if (tick) begin
                    if (hold_cnt == '0)   state_next = GATE_IDLE;
                    else                  hold_next  = hold_cnt - 1'b1;
                end
            end
            default: state_next = GATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= GATE_IDLE;
            hold_cnt  <= '0;
            gate_out  <= 1'b0;
            gate_rise <= 1'b0;
        end else begin
            state     <= state_next;
            hold_cnt  <= hold_next;
            gate_out  <= (state_next != GATE_IDLE);
            gate_rise <= rise_next;
        end
    end

endmodule

// File: tb/tb_envelope_follower.sv
// Bench for envelope_follower: tick-indexed vector table, hand sequences for
// hysteresis/collision/reset, and randomized traffic against a behavioural model.
module tb_envelope_follower;
    localparam int DATA_W   = 16;
    localparam int TICK_DIV = 4;
    localparam int DC_SHIFT = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] sample_in = '0;
    logic [5:0]         attack_rate = '0, release_rate = '0;
    logic [5:0]         thr_on = 6'd63, thr_off = 6'd63, hold_ticks = '0;
    logic [5:0]         env_level;
    logic               gate_out, gate_rise;

    envelope_follower #(.DATA_W(DATA_W), .TICK_DIV(TICK_DIV), .DC_SHIFT(DC_SHIFT)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .attack_rate  (attack_rate),
        .release_rate (release_rate),
        .thr_on       (thr_on),
        .thr_off      (thr_off),
        .hold_ticks   (hold_ticks),
        .env_level    (env_level),
        .gate_out     (gate_out),
        .gate_rise    (gate_rise)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0, rise_cnt = 0;
    // model state: tick phase, window peak, envelope, gate (0 idle,1 on,2 hold)
    int m_tc = 0, m_peak = 0, m_env = 0, m_gs = 0, m_hold = 0, m_gate = 0, m_rise = 0;
    int m_xp = 0, m_yp = 0, m_dv = 0, m_dy = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock of the specified behaviour, evaluated on pre-edge inputs.
    task automatic model_update();
        int rv, rs, mg, p, tk, gs, thr_e, y;
        tk = (m_tc == TICK_DIV - 1);
`ifdef ENV_FOLLOWER_DC_BLOCK_EN
        rv = m_dv;
        rs = m_dy;
        if (sample_valid) begin
            y = int'(sample_in) - m_xp + m_yp - (m_yp >>> DC_SHIFT);
            if (y > 32767) y = 32767;
            if (y < -32768) y = -32768;
            m_xp = int'(sample_in);
            m_yp = y;
            m_dy = y;
        end
        m_dv = sample_valid;
`else
        y  = 0;
        rv = sample_valid;
        rs = int'(sample_in);
`endif
        mg = (rs < 0) ? -rs : rs;
        if (mg > 32767) mg = 32767;
        mg = mg / 512;
        p = m_peak;
        if (rv != 0 && mg > p) p = mg;
        thr_e  = imin(int'(thr_off), int'(thr_on));
        gs     = m_gs;
        m_rise = 0;
        if (m_gs == 0) begin
            if (m_env >= int'(thr_on)) begin gs = 1; m_rise = 1; end
        end else if (m_gs == 1) begin
            if (m_env < thr_e) begin gs = 2; m_hold = int'(hold_ticks); end
        end else begin
            if (m_env >= int'(thr_on)) gs = 1;
            else if (tk != 0) begin
                if (m_hold == 0) gs = 0;
                else m_hold--;
            end
        end
        m_gs   = gs;
        m_gate = (gs != 0);
        if (tk != 0) begin
            if (p > m_env)      m_env += imin(int'(attack_rate), p - m_env);
            else if (p < m_env) m_env -= imin(int'(release_rate), m_env - p);
            m_peak = 0;
        end else m_peak = p;
        m_tc = (tk != 0) ? 0 : m_tc + 1;
        if (!reset) begin
            m_tc = 0; m_peak = 0; m_env = 0; m_gs = 0; m_hold = 0; m_gate = 0; m_rise = 0;
            m_xp = 0; m_yp = 0; m_dv = 0; m_dy = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("model env_level", int'(env_level), m_env);
        check("model gate_out", int'(gate_out), m_gate);
        check("model gate_rise", int'(gate_rise), m_rise);
        if (gate_rise) rise_cnt++;
    endtask

    // Advance through the next tick edge; env_level is then the post-tick value.
    task automatic run_tick();
        bit seen = 0;
        for (int i = 0; i <= TICK_DIV && !seen; i++) begin
            seen = (m_tc == TICK_DIV - 1);
            step();
        end
        if (!seen) check("tick timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic [15:0] s;
        logic [5:0]  att;
        logic [5:0]  rel;
        int          exp_env;
    } vec_t;

    vec_t vecs[21];

    initial begin
        vecs = '{
            '{1'b1, 16'h7FFF, 6'd8, 6'd10, 8},  '{1'b1, 16'h7FFF, 6'd8, 6'd10, 16},
            '{1'b1, 16'h7FFF, 6'd8, 6'd10, 24}, '{1'b1, 16'h7FFF, 6'd8, 6'd10, 32},
            '{1'b1, 16'h7FFF, 6'd8, 6'd10, 40}, '{1'b1, 16'h7FFF, 6'd8, 6'd10, 48},
            '{1'b1, 16'h7FFF, 6'd8, 6'd10, 56}, '{1'b1, 16'h7FFF, 6'd8, 6'd10, 63},
            '{1'b1, 16'h7FFF, 6'd8, 6'd10, 63},
            '{1'b0, 16'h0000, 6'd8, 6'd10, 53}, '{1'b0, 16'h0000, 6'd8, 6'd10, 43},
            '{1'b0, 16'h0000, 6'd8, 6'd10, 33}, '{1'b0, 16'h0000, 6'd8, 6'd10, 23},
            '{1'b0, 16'h0000, 6'd8, 6'd10, 13}, '{1'b0, 16'h0000, 6'd8, 6'd10, 3},
            '{1'b0, 16'h0000, 6'd8, 6'd10, 0},  '{1'b0, 16'h0000, 6'd8, 6'd10, 0},
            '{1'b1, 16'h7FFF, 6'd0, 6'd10, 0},  '{1'b1, 16'h8000, 6'd63, 6'd10, 63},
            '{1'b0, 16'h0000, 6'd63, 6'd0, 63}, '{1'b0, 16'h0000, 6'd63, 6'd63, 0}
        };

        do_reset();
        check("reset env_level", int'(env_level), 0);
        check("reset gate_out", int'(gate_out), 0);

`ifndef ENV_FOLLOWER_DC_BLOCK_EN
        // slew table: attack, release, attack=0, 0x8000 saturation, release=0
        foreach (vecs[i]) begin
            sample_valid = vecs[i].v;
            sample_in    = vecs[i].s;
            attack_rate  = vecs[i].att;
            release_rate = vecs[i].rel;
            run_tick();
            check($sformatf("table[%0d] env", i), int'(env_level), vecs[i].exp_env);
        end

        // hysteresis and hold
        do_reset();
        thr_on = 40; thr_off = 20; hold_ticks = 3;
        attack_rate = 8; release_rate = 10;
        sample_valid = 1; sample_in = 16'h7FFF; rise_cnt = 0;
        repeat (6) run_tick();
        check("hyst gate on", int'(gate_out), 1);
        check("hyst one rise", rise_cnt, 1);
        sample_valid = 0;
        repeat (3) run_tick();
        check("hyst env 18", int'(env_level), 18);
        repeat (3) run_tick();
        check("hold still open", int'(gate_out), 1);
        run_tick();
        check("hold expired", int'(gate_out), 0);
        sample_valid = 1;
        repeat (6) run_tick();
        sample_valid = 0;
        repeat (3) run_tick();
        run_tick();
        sample_valid = 1; attack_rate = 63; rise_cnt = 0;
        run_tick();
        step(); step();
        repeat (5) run_tick();
        check("rehit gate on", int'(gate_out), 1);
        check("rehit no rise", rise_cnt, 0);

        // tick collision: peak 10, tick-cycle sample mag6=50
        do_reset();
        attack_rate = 63; release_rate = 0; thr_on = 63; thr_off = 63; hold_ticks = 0;
        sample_valid = 0;
        run_tick();
        sample_valid = 1; sample_in = 16'h1400;
        step();
        sample_valid = 0;
        for (int i = 0; i < TICK_DIV && m_tc != TICK_DIV - 1; i++) step();
        sample_valid = 1; sample_in = 16'h6400;
        step();
        sample_valid = 0;
        check("collision env", int'(env_level), 50);

        // reset mid-attack
        do_reset();
        thr_on = 20; thr_off = 10; attack_rate = 10;
        sample_valid = 1; sample_in = 16'h7FFF;
        repeat (3) run_tick();
        step();
        check("pre-reset env", int'(env_level), 30);
        check("pre-reset gate", int'(gate_out), 1);
        reset = 0;
        step();
        check("midreset env", int'(env_level), 0);
        check("midreset gate", int'(gate_out), 0);
        reset = 1; attack_rate = 63; thr_on = 63;
        repeat (3) step();
        check("tick phase after reset", int'(env_level), 0);
        step();
        check("first tick after reset", int'(env_level), 63);
`endif

        // constant 0x4000 input: DC blocker removes it, plain path settles at 32
        do_reset();
        attack_rate = 63; release_rate = 63; thr_on = 40; thr_off = 20; hold_ticks = 2;
        sample_valid = 1; sample_in = 16'h4000;
`ifdef ENV_FOLLOWER_DC_BLOCK_EN
        repeat (400) run_tick();
        check("dc env decays", int'(env_level), 0);
`else
        repeat (3) run_tick();
        check("dc env 32", int'(env_level), 32);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) begin
                attack_rate  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
                release_rate = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
                thr_on       = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom);
                thr_off      = 6'($urandom);
                hold_ticks   = 6'($urandom_range(0, 5));
            end
            sample_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0:       sample_in = 16'h8000;
                1:       sample_in = 16'($urandom_range(0, 4095));
                default: sample_in = 16'($urandom);
            endcase
            reset = ($urandom_range(0, 399) != 0);
            step();
        end
        reset = 1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
